// File: rtl/erc_pkg.sv
// Shared types and constants for the exhaustive response checker.
// Holds the FSM encoding, the default input count and the MISR polynomial and seed.
package erc_pkg;

  localparam int N_IN_DEF = 5;

  // x^16 + x^12 + x^5 + 1, with the x^16 term implied by the shift-out bit
  localparam logic [15:0] MISR_POLY = 16'h1021;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    EVAL    = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [15:0] misr_next(input logic [15:0] cur, input logic [15:0] din);
    logic [15:0] shifted;
    shifted = {cur[14:0], 1'b0} ^ (cur[15] ? MISR_POLY : 16'h0000);
    return shifted ^ din;
  endfunction

endpackage

// File: rtl/exhaustive_resp_checker_if.sv
// Stimulus/response bus between the sweep harness and the response checker.
// The signature signal exists only when SIG_MISR_EN is defined.
interface exhaustive_resp_checker_if #(
  parameter int N_IN = erc_pkg::N_IN_DEF
);

  logic                 start;
  logic                 vec_valid;
  logic [N_IN-1:0]      vec_in;
  logic                 o_p;
  logic                 ready;
  logic                 done;
  logic                 pass;
  logic [N_IN:0]        mismatch_cnt;
  logic                 first_fail_vld;
  logic [N_IN-1:0]      first_fail_idx;
  logic                 seq_err;
  logic [2**N_IN-1:0]   observed;
`ifdef SIG_MISR_EN
  logic [15:0]          signature;
`endif

  modport master (
    output start, vec_valid, vec_in, o_p,
    input  ready, done, pass, mismatch_cnt, first_fail_vld, first_fail_idx,
    input  seq_err, observed
`ifdef SIG_MISR_EN
    , input signature
`endif
  );

  modport slave (
    input  start, vec_valid, vec_in, o_p,
    output ready, done, pass, mismatch_cnt, first_fail_vld, first_fail_idx,
    output seq_err, observed
`ifdef SIG_MISR_EN
    , output signature
`endif
  );

endinterface

// File: rtl/erc_misr.sv
// 16-bit multiple-input signature register; clr reloads the seed, en folds din in.
// One-cycle update, no backpressure: every enabled cycle is absorbed.
module erc_misr
  import erc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= MISR_SEED;
    end else if (clr) begin
      sig <= MISR_SEED;
    end else if (en) begin
      sig <= misr_next(sig, din);
    end
  end

endmodule

// File: rtl/exhaustive_resp_checker.sv
// Captures o_p for each swept vector, scores it against GOLDEN; done 2 cycles after the last accept.
// ready is high only in COLLECT; optional signature output under SIG_MISR_EN.
module exhaustive_resp_checker
  import erc_pkg::*;
#(
  parameter int                 N_IN   = N_IN_DEF,
  parameter logic [2**N_IN-1:0] GOLDEN = '0
) (
  input logic                      clk,
  input logic                      rst_n,
  exhaustive_resp_checker_if.slave bus
);

  localparam int            DEPTH    = 2**N_IN;
  localparam logic [N_IN:0] LAST_IDX = (N_IN+1)'(DEPTH - 1);
  localparam logic [N_IN:0] CNT_MAX  = (N_IN+1)'(DEPTH);

  state_t            state;
  logic [N_IN:0]     exp_idx;
  logic              ready_r;
  logic              done_r;
  logic              pass_r;
  logic [N_IN:0]     mm_cnt;
  logic              ffv_r;
  logic [N_IN-1:0]   ffi_r;
  logic              seq_r;
  logic [DEPTH-1:0]  obs_r;

  logic              restart;
  logic              accept;
  logic              miss;

  // start is honoured everywhere except the single EVAL cycle; it wins over a same-cycle vec_valid
  assign restart = bus.start && (state != EVAL);
  assign accept  = (state == COLLECT) && bus.vec_valid && !bus.start;
  assign miss    = bus.o_p != GOLDEN[bus.vec_in];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      exp_idx <= '0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      mm_cnt  <= '0;
      ffv_r   <= 1'b0;
      ffi_r   <= '0;
      seq_r   <= 1'b0;
      obs_r   <= '0;
    end else if (restart) begin
      state   <= COLLECT;
      exp_idx <= '0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
      mm_cnt  <= '0;
      ffv_r   <= 1'b0;
      ffi_r   <= '0;
      seq_r   <= 1'b0;
      obs_r   <= '0;
    end else if (accept) begin
      // Table is addressed by the applied vector so duplicates overwrite rather than shift
      obs_r[bus.vec_in] <= bus.o_p;
      if (miss) begin
        if (mm_cnt != CNT_MAX) begin
          mm_cnt <= mm_cnt + 1'b1;
        end
        if (!ffv_r) begin
          ffv_r <= 1'b1;
          ffi_r <= bus.vec_in;
        end
      end
      if ({1'b0, bus.vec_in} != exp_idx) begin
        seq_r <= 1'b1;
      end
      exp_idx <= exp_idx + 1'b1;
      if (exp_idx == LAST_IDX) begin
        state   <= EVAL;
        ready_r <= 1'b0;
      end
    end else if (state == EVAL) begin
      pass_r <= (mm_cnt == '0) && !seq_r;
      done_r <= 1'b1;
      state  <= DONE;
    end
  end

  assign bus.ready          = ready_r;
  assign bus.done           = done_r;
  assign bus.pass           = pass_r;
  assign bus.mismatch_cnt   = mm_cnt;
  assign bus.first_fail_vld = ffv_r;
  assign bus.first_fail_idx = ffi_r;
  assign bus.seq_err        = seq_r;
  assign bus.observed       = obs_r;

`ifdef SIG_MISR_EN
  erc_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (restart),
    .en    (accept),
    .din   ({{(16-N_IN-1){1'b0}}, bus.vec_in, bus.o_p}),
    .sig   (bus.signature)
  );
`endif

endmodule

// File: tb/tb_exhaustive_resp_checker.sv
// Bench for exhaustive_resp_checker: two instances (AND-style and parity-style golden tables)
// driven in lockstep, checked against a queue-based sweep model plus a table of hand-derived results.
module tb_exhaustive_resp_checker;

  logic clk;
  logic rst_n;

  logic       start;
  logic       vld;
  logic [4:0] vec;
  logic       opa;
  logic       opx;

  logic [31:0] ga;
  logic [31:0] gx;

  int n_vec;
  int n_err;

  exhaustive_resp_checker_if #(.N_IN(5)) bus_a ();
  exhaustive_resp_checker_if #(.N_IN(5)) bus_x ();

  assign bus_a.start     = start;
  assign bus_a.vec_valid = vld;
  assign bus_a.vec_in    = vec;
  assign bus_a.o_p       = opa;
  assign bus_x.start     = start;
  assign bus_x.vec_valid = vld;
  assign bus_x.vec_in    = vec;
  assign bus_x.o_p       = opx;

  exhaustive_resp_checker #(.N_IN(5), .GOLDEN(32'h8000_0000)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  exhaustive_resp_checker #(.N_IN(5), .GOLDEN(32'h6996_9669)) dut_x (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sweep model: phase 0 idle, 1 collecting, 2 evaluating, 3 done; accepted vectors kept in order
  int q_vec[$];
  bit q_oa[$];
  bit q_ox[$];
  int phase;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q_vec.delete();
    q_oa.delete();
    q_ox.delete();
  endtask

  task automatic check_dut(input string tag, input logic [31:0] g, input bit use_x,
                           input logic rdy, input logic dn, input logic ps,
                           input logic [5:0] mm, input logic ffv, input logic [4:0] ffi,
                           input logic se, input logic [31:0] obs);
    logic [31:0] e_obs;
    int  e_mm;
    bit  e_ffv;
    int  e_ffi;
    bit  e_seq;
    bit  op;
    e_obs = '0; e_mm = 0; e_ffv = 0; e_ffi = 0; e_seq = 0;
    for (int k = 0; k < q_vec.size(); k++) begin
      op = use_x ? q_ox[k] : q_oa[k];
      e_obs[q_vec[k]] = op;
      if (op != g[q_vec[k]]) begin
        e_mm++;
        if (!e_ffv) begin
          e_ffv = 1;
          e_ffi = q_vec[k];
        end
      end
      if (q_vec[k] != k) e_seq = 1;
    end
    if (e_mm > 32) e_mm = 32;
    chk({tag, ".ready"},    64'(rdy), 64'(phase == 1));
    chk({tag, ".done"},     64'(dn),  64'(phase == 3));
    chk({tag, ".pass"},     64'(ps),  64'(phase == 3 && e_mm == 0 && !e_seq));
    chk({tag, ".mm_cnt"},   64'(mm),  64'(e_mm));
    chk({tag, ".ff_vld"},   64'(ffv), 64'(e_ffv));
    chk({tag, ".ff_idx"},   64'(ffi), 64'(e_ffi));
    chk({tag, ".seq_err"},  64'(se),  64'(e_seq));
    chk({tag, ".observed"}, 64'(obs), 64'(e_obs));
  endtask

  task automatic check_both();
    check_dut("a", ga, 1'b0, bus_a.ready, bus_a.done, bus_a.pass, bus_a.mismatch_cnt,
              bus_a.first_fail_vld, bus_a.first_fail_idx, bus_a.seq_err, bus_a.observed);
    check_dut("x", gx, 1'b1, bus_x.ready, bus_x.done, bus_x.pass, bus_x.mismatch_cnt,
              bus_x.first_fail_vld, bus_x.first_fail_idx, bus_x.seq_err, bus_x.observed);
  endtask

  // One clock: model follows the inputs present at the edge, DUT sampled 1 time unit later
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
      phase = 0;
    end else if (phase == 2) begin
      phase = 3;
    end else if (start) begin
      model_clear();
      phase = 1;
    end else if (phase == 1 && vld) begin
      q_vec.push_back(int'(vec));
      q_oa.push_back(opa);
      q_ox.push_back(opx);
      if (q_vec.size() == 32) phase = 2;
    end
    #1;
    check_both();
  endtask

  task automatic drive(input bit s, input bit v, input int vv, input bit a, input bit x);
    start = s;
    vld   = v;
    vec   = 5'(vv);
    opa   = a;
    opx   = x;
    cycle();
    start = 1'b0;
    vld   = 1'b0;
  endtask

  task automatic clean_sweep();
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 32; k++) drive(1'b0, 1'b1, k, ga[k], gx[k]);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  typedef struct {
    int          mode;
    logic [31:0] obs_a;
    logic [31:0] obs_x;
    int          mm_a;
    int          mm_x;
    bit          ffv_a;
    int          ffi_a;
    bit          ffv_x;
    int          ffi_x;
    bit          seq;
    bit          pass_a;
    bit          pass_x;
  } rec_t;

  rec_t tbl[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    ga = 32'h8000_0000;
    gx = 32'h6996_9669;
    phase = 0;
    start = 1'b0; vld = 1'b0; vec = '0; opa = 1'b0; opx = 1'b0;

    // mode 0 clean; mode 1 stuck-at-0 on a, flips on 3 and 17 on x; mode 2 repeats 5 and skips 6
    tbl[0] = '{0, 32'h8000_0000, 32'h6996_9669, 0, 0, 0, 0,  0, 0, 0, 1, 1};
    tbl[1] = '{1, 32'h0000_0000, 32'h6994_9661, 1, 2, 1, 31, 1, 3, 0, 0, 0};
    tbl[2] = '{2, 32'h8000_0000, 32'h6996_9629, 0, 0, 0, 0,  0, 0, 1, 0, 0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 7, 1'b1, 1'b1);
    #2 rst_n = 1'b1;

    // vec_valid while idle must not disturb anything
    drive(1'b0, 1'b1, 31, 1'b1, 1'b1);
    chk("idle_ignore.obs", 64'(bus_a.observed), 64'h0);

    for (int r = 0; r < 3; r++) begin
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
      for (int k = 0; k < 32; k++) begin
        int v;
        bit a;
        bit x;
        v = (tbl[r].mode == 2 && k == 6) ? 5 : k;
        a = ga[v];
        x = gx[v];
        if (tbl[r].mode == 1) begin
          a = 1'b0;
          if (v == 3 || v == 17) x = ~x;
        end
        drive(1'b0, 1'b1, v, a, x);
      end
      chk($sformatf("row%0d.lat_eval_done", r), 64'(bus_a.done), 64'h0);
      chk($sformatf("row%0d.lat_eval_ready", r), 64'(bus_a.ready), 64'h0);
      drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
      chk($sformatf("row%0d.lat_done", r), 64'(bus_a.done), 64'h1);
      chk($sformatf("row%0d.obs_a", r),  64'(bus_a.observed), 64'(tbl[r].obs_a));
      chk($sformatf("row%0d.obs_x", r),  64'(bus_x.observed), 64'(tbl[r].obs_x));
      chk($sformatf("row%0d.mm_a", r),   64'(bus_a.mismatch_cnt), 64'(tbl[r].mm_a));
      chk($sformatf("row%0d.mm_x", r),   64'(bus_x.mismatch_cnt), 64'(tbl[r].mm_x));
      chk($sformatf("row%0d.ffv_a", r),  64'(bus_a.first_fail_vld), 64'(tbl[r].ffv_a));
      chk($sformatf("row%0d.ffi_a", r),  64'(bus_a.first_fail_idx), 64'(tbl[r].ffi_a));
      chk($sformatf("row%0d.ffv_x", r),  64'(bus_x.first_fail_vld), 64'(tbl[r].ffv_x));
      chk($sformatf("row%0d.ffi_x", r),  64'(bus_x.first_fail_idx), 64'(tbl[r].ffi_x));
      chk($sformatf("row%0d.seq_a", r),  64'(bus_a.seq_err), 64'(tbl[r].seq));
      chk($sformatf("row%0d.seq_x", r),  64'(bus_x.seq_err), 64'(tbl[r].seq));
      chk($sformatf("row%0d.pass_a", r), 64'(bus_a.pass), 64'(tbl[r].pass_a));
      chk($sformatf("row%0d.pass_x", r), 64'(bus_x.pass), 64'(tbl[r].pass_x));
      // DONE holds results against stray valids carrying wrong responses
      drive(1'b0, 1'b1, 31, ~ga[31], ~gx[31]);
      chk($sformatf("row%0d.done_hold", r), 64'(bus_a.mismatch_cnt), 64'(tbl[r].mm_a));
    end

    // Abort after 10 bad accepts; the valid arriving with start is dropped
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, k, ~ga[k], ~gx[k]);
    drive(1'b1, 1'b1, 10, ~ga[10], ~gx[10]);
    chk("abort.mm_x", 64'(bus_x.mismatch_cnt), 64'h0);
    for (int k = 0; k < 32; k++) drive(1'b0, 1'b1, k, ga[k], gx[k]);
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("abort.pass_a", 64'(bus_a.pass), 64'h1);
    chk("abort.pass_x", 64'(bus_x.pass), 64'h1);

    // Asynchronous reset after 20 accepts
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b1, k, 1'b1, ~gx[k]);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    phase = 0;
    chk("rst.obs_a", 64'(bus_a.observed), 64'h0);
    chk("rst.mm_x", 64'(bus_x.mismatch_cnt), 64'h0);
    chk("rst.ready", 64'(bus_a.ready), 64'h0);
    check_both();
    @(negedge clk);
    rst_n = 1'b1;
    clean_sweep();
    chk("post_rst.pass_a", 64'(bus_a.pass), 64'h1);
    chk("post_rst.pass_x", 64'(bus_x.pass), 64'h1);

    // Randomised sweeps: gaps, occasional wrong index, wrong response or restart
    for (int it = 0; it < 12; it++) begin
      int cyc;
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
      cyc = 0;
      while (phase != 3 && cyc < 300) begin
        if ($urandom_range(0, 99) < 2) begin
          drive(1'b1, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
        end else if ($urandom_range(0, 99) < 75) begin
          int v;
          bit a;
          bit x;
          v = ($urandom_range(0, 99) < 92) ? (q_vec.size() % 32) : int'($urandom_range(0, 31));
          a = ga[v] ^ ($urandom_range(0, 99) < 10);
          x = gx[v] ^ ($urandom_range(0, 99) < 10);
          drive(1'b0, 1'b1, v, a, x);
        end else begin
          drive(1'b0, 1'b0, int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        cyc++;
      end
      chk($sformatf("rand%0d.done", it), 64'(bus_a.done), 64'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
